// File: rtl/bp_update_scheduler.sv
// Branch-resolution update scheduler: in-order FIFO between the branch FUs and the
// predictor's single update port, with flush squash and a saturating drop counter.
`ifndef XLEN
`define XLEN 32
`endif

module bp_update_scheduler #(
  parameter int unsigned NRES    = 2,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DEPTH_W = 3,
  parameter int unsigned XLEN    = `XLEN
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NRES-1:0]            resolve_valid,
  input  logic [NRES-1:0][XLEN-1:0]  resolve_pc,
  input  logic [NRES-1:0]            resolve_direction,
  input  logic [NRES-1:0][XLEN-1:0]  resolve_target,
  output logic                       resolve_ready,
  input  logic                       flush,
  output logic                       update_EN,
  output logic [XLEN-1:0]            update_pc,
  output logic                       update_direction,
  output logic [XLEN-1:0]            update_target,
  output logic [DEPTH_W:0]           occupancy,
  output logic [15:0]                drop_count
);

  localparam int unsigned CNT_W  = DEPTH_W + 1;
  localparam int unsigned DROP_W = 16;
  localparam int unsigned SUM_W  = DROP_W + 1;

  logic [XLEN-1:0]    r_pc_mem  [DEPTH];
  logic [XLEN-1:0]    r_tgt_mem [DEPTH];
  logic [DEPTH-1:0]   r_dir_mem;
  logic [DEPTH_W-1:0] r_head;
  logic [DEPTH_W-1:0] r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [DROP_W-1:0]  r_drop;

  logic                         w_ready;
  logic                         w_deq;
  logic [CNT_W-1:0]             w_n_valid;
  logic [CNT_W-1:0]             w_n_young;
  logic [CNT_W-1:0]             w_n_enq;
  logic [DEPTH_W-1:0]           w_run;
  logic [NRES-1:0][DEPTH_W-1:0] w_slot;
  logic [NRES-1:0]              w_wr;
  logic [SUM_W-1:0]             w_drop_inc;
  logic [SUM_W-1:0]             w_drop_sum;

  // Accept only when every port could land; based on registered count alone.
  assign w_ready = (r_count <= CNT_W'(DEPTH - NRES));
  assign w_deq   = (r_count != '0) && !flush;

  // Popcounts and packed write slots: valid ports land contiguously from the tail.
  always_comb begin
    w_n_valid = '0;
    w_n_young = '0;
    w_run     = '0;
    w_slot    = '0;
    w_wr      = '0;
    for (int i = 0; i < int'(NRES); i++) begin
      w_slot[i] = r_tail + w_run;
      if (resolve_valid[i]) begin
        w_run     = w_run + DEPTH_W'(1);
        w_n_valid = w_n_valid + CNT_W'(1);
        if (i > 0) w_n_young = w_n_young + CNT_W'(1);
      end
      // On flush only port 0 (the mispredicting branch) survives, written at the old tail.
      if (flush) w_wr[i] = (i == 0) && resolve_valid[i];
      else       w_wr[i] = w_ready && resolve_valid[i];
    end
  end

  // Entries enqueued and resolutions discarded this cycle.
  always_comb begin
    w_n_enq    = '0;
    w_drop_inc = '0;
    if (flush) begin
      w_n_enq    = CNT_W'(resolve_valid[0]);
      w_drop_inc = SUM_W'(r_count) + SUM_W'(w_n_young);
    end else if (w_ready) begin
      w_n_enq    = w_n_valid;
    end else begin
      w_drop_inc = SUM_W'(w_n_valid);
    end
    w_drop_sum = SUM_W'(r_drop) + w_drop_inc;
  end

  // Payload storage; no reset needed because the head mux hides stale data when empty.
  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(NRES); i++) begin
      if (w_wr[i]) begin
        r_pc_mem[w_slot[i]]  <= resolve_pc[i];
        r_tgt_mem[w_slot[i]] <= resolve_target[i];
        r_dir_mem[w_slot[i]] <= resolve_direction[i];
      end
    end
  end

  // Pointer, count and saturating drop-counter state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_drop  <= '0;
    end else begin
      r_tail <= r_tail + DEPTH_W'(w_n_enq);
      if (flush) begin
        r_head  <= r_tail;
        r_count <= w_n_enq;
      end else begin
        r_head  <= r_head + DEPTH_W'(w_deq);
        r_count <= r_count + w_n_enq - CNT_W'(w_deq);
      end
      r_drop <= w_drop_sum[DROP_W] ? {DROP_W{1'b1}} : w_drop_sum[DROP_W-1:0];
    end
  end

  // Head entry presented to the predictor; zero while empty.
  always_comb begin
    update_pc        = '0;
    update_direction = 1'b0;
    update_target    = '0;
    if (r_count != '0) begin
      update_pc        = r_pc_mem[r_head];
      update_direction = r_dir_mem[r_head];
      update_target    = r_tgt_mem[r_head];
    end
  end

  assign update_EN     = w_deq;
  assign resolve_ready = w_ready;
  assign occupancy     = r_count;
  assign drop_count    = r_drop;

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Scoreboard bench for bp_update_scheduler: expected entries queued at enqueue time,
// popped and compared whenever the predictor update strobe is expected.
`timescale 1ns/1ps
`ifndef XLEN
`define XLEN 32
`endif

module tb_bp_update_scheduler;

  localparam int unsigned NRES    = 2;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned DEPTH_W = 3;
  localparam int unsigned XLEN    = `XLEN;
  localparam int unsigned CNT_W   = DEPTH_W + 1;

  logic                      clock = 1'b0;
  logic                      reset = 1'b0;
  logic [NRES-1:0]           resolve_valid = '0;
  logic [NRES-1:0][XLEN-1:0] resolve_pc = '0;
  logic [NRES-1:0]           resolve_direction = '0;
  logic [NRES-1:0][XLEN-1:0] resolve_target = '0;
  logic                      resolve_ready;
  logic                      flush = 1'b0;
  logic                      update_EN;
  logic [XLEN-1:0]           update_pc;
  logic                      update_direction;
  logic [XLEN-1:0]           update_target;
  logic [DEPTH_W:0]          occupancy;
  logic [15:0]               drop_count;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic            dir;
    logic [XLEN-1:0] tgt;
  } ent_t;

  ent_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned m_drop   = 0;
  bit          mon_en   = 1'b0;
  ent_t        mon_e;
  logic        mon_exp_en;

  bp_update_scheduler #(
    .NRES(NRES), .DEPTH(DEPTH), .DEPTH_W(DEPTH_W), .XLEN(XLEN)
  ) dut (
    .clock(clock), .reset(reset),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_direction(resolve_direction), .resolve_target(resolve_target),
    .resolve_ready(resolve_ready), .flush(flush),
    .update_EN(update_EN), .update_pc(update_pc),
    .update_direction(update_direction), .update_target(update_target),
    .occupancy(occupancy), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: occupancy and head entry checked mid-cycle against the queue.
  always @(negedge clock) begin
    if (mon_en) begin
      n_checks++;
      if (occupancy !== CNT_W'(sb.size())) begin
        n_fail++;
        $display("FAIL mon_occupancy: got %0d expected %0d", occupancy, sb.size());
      end
      mon_exp_en = (sb.size() != 0) && !flush;
      n_checks++;
      if (update_EN !== mon_exp_en) begin
        n_fail++;
        $display("FAIL mon_update_en: got %b expected %b", update_EN, mon_exp_en);
      end
      if (mon_exp_en) begin
        mon_e = sb.pop_front();
        n_checks++;
        if (update_pc !== mon_e.pc || update_direction !== mon_e.dir || update_target !== mon_e.tgt) begin
          n_fail++;
          $display("FAIL mon_head: got pc=%h dir=%b tgt=%h expected pc=%h dir=%b tgt=%h",
                   update_pc, update_direction, update_target, mon_e.pc, mon_e.dir, mon_e.tgt);
        end
      end else if (sb.size() == 0) begin
        n_checks++;
        if (update_pc !== '0 || update_direction !== 1'b0 || update_target !== '0) begin
          n_fail++;
          $display("FAIL mon_empty_zero: got pc=%h dir=%b tgt=%h expected zeros",
                   update_pc, update_direction, update_target);
        end
      end
    end
  end

  function automatic void add_drop(input int unsigned n);
    m_drop = (m_drop + n > 32'd65535) ? 32'd65535 : m_drop + n;
  endfunction

  // One cycle of stimulus; queue bookkeeping happens after the monitor has sampled.
  task automatic drive_cycle(input logic [1:0] v,
                             input logic [XLEN-1:0] pc0, input logic d0, input logic [XLEN-1:0] t0,
                             input logic [XLEN-1:0] pc1, input logic d1, input logic [XLEN-1:0] t1,
                             input logic fl);
    bit   rdy;
    ent_t e0;
    ent_t e1;
    @(posedge clock);
    #1;
    resolve_valid        = v;
    resolve_pc[0]        = pc0;
    resolve_direction[0] = d0;
    resolve_target[0]    = t0;
    resolve_pc[1]        = pc1;
    resolve_direction[1] = d1;
    resolve_target[1]    = t1;
    flush                = fl;
    rdy = (sb.size() <= int'(DEPTH - NRES));
    e0.pc = pc0; e0.dir = d0; e0.tgt = t0;
    e1.pc = pc1; e1.dir = d1; e1.tgt = t1;
    @(negedge clock);
    #1;
    if (fl) begin
      add_drop(int'(sb.size()) + int'(v[1]));
      sb.delete();
      if (v[0]) sb.push_back(e0);
    end else if (rdy) begin
      if (v[0]) sb.push_back(e0);
      if (v[1]) sb.push_back(e1);
    end else begin
      add_drop(int'(v[0]) + int'(v[1]));
    end
  endtask

  task automatic idle();
    drive_cycle(2'b00, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic dual(input logic [XLEN-1:0] base);
    drive_cycle(2'b11, base, 1'b0, base + XLEN'(32'h1000),
                base + XLEN'(4), 1'b1, base + XLEN'(32'h2004), 1'b0);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    n_checks++;
    if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    n_checks++;
    if (update_EN !== 1'b0) begin n_fail++; $display("FAIL reset_update_en: got %b expected 0", update_EN); end
    n_checks++;
    if (resolve_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", resolve_ready); end
    n_checks++;
    if (drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
    n_checks++;
    if (update_pc !== '0 || update_target !== '0) begin
      n_fail++; $display("FAIL reset_update_payload: got pc=%h tgt=%h expected 0", update_pc, update_target);
    end
    #1 reset = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    drive_cycle(2'b01, XLEN'(32'h100), 1'b1, XLEN'(32'h200), '0, 1'b0, '0, 1'b0);
    n_checks++;
    if (update_EN !== 1'b0 || occupancy !== 4'd0) begin
      n_fail++; $display("FAIL single_no_bypass: got en=%b occ=%0d expected en=0 occ=0", update_EN, occupancy);
    end
    idle();
    n_checks++;
    if (update_EN !== 1'b1 || update_pc !== XLEN'(32'h100) || update_direction !== 1'b1 ||
        update_target !== XLEN'(32'h200) || occupancy !== 4'd1) begin
      n_fail++;
      $display("FAIL single_update: got en=%b pc=%h dir=%b tgt=%h occ=%0d expected en=1 pc=100 dir=1 tgt=200 occ=1",
               update_EN, update_pc, update_direction, update_target, occupancy);
    end
    idle();
    n_checks++;
    if (update_EN !== 1'b0 || occupancy !== 4'd0) begin
      n_fail++; $display("FAIL single_drained: got en=%b occ=%0d expected en=0 occ=0", update_EN, occupancy);
    end
  endtask

  // Two resolutions per cycle against one drain per cycle: count climbs by one each cycle.
  task automatic test_dual_fill();
    for (int k = 0; k < 7; k++) begin
      dual(XLEN'(32'h10) + XLEN'(8 * k));
      n_checks++;
      if (resolve_ready !== (k < 6)) begin
        n_fail++; $display("FAIL dual_ready_k%0d: got %b expected %b", k, resolve_ready, (k < 6));
      end
    end
    n_checks++;
    if (occupancy !== 4'd7) begin n_fail++; $display("FAIL dual_full_occ: got %0d expected 7", occupancy); end
  endtask

  task automatic test_overflow();
    for (int j = 0; j < 6; j++) begin
      dual(XLEN'(32'h100) + XLEN'(8 * j));
      n_checks++;
      if (resolve_ready !== (j % 2 == 0)) begin
        n_fail++; $display("FAIL ovf_ready_j%0d: got %b expected %b", j, resolve_ready, (j % 2 == 0));
      end
    end
    idle();
    n_checks++;
    if (drop_count !== 16'd8 || drop_count !== 16'(m_drop)) begin
      n_fail++; $display("FAIL ovf_drop_count: got %0d expected 8 (model %0d)", drop_count, m_drop);
    end
    for (int i = 0; i < 12 && occupancy != 0; i++) idle();
    n_checks++;
    if (occupancy !== 4'd0) begin n_fail++; $display("FAIL ovf_drain_timeout: got occ=%0d expected 0", occupancy); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 4; k++) dual(XLEN'(32'h400) + XLEN'(8 * k));
    drive_cycle(2'b11, XLEN'(32'h40), 1'b1, XLEN'(32'h80), XLEN'(32'h44), 1'b0, XLEN'(32'h88), 1'b1);
    n_checks++;
    if (update_EN !== 1'b0 || occupancy !== 4'd5) begin
      n_fail++; $display("FAIL flush_cycle: got en=%b occ=%0d expected en=0 occ=5", update_EN, occupancy);
    end
    idle();
    n_checks++;
    if (update_EN !== 1'b1 || update_pc !== XLEN'(32'h40) || update_target !== XLEN'(32'h80) || occupancy !== 4'd1) begin
      n_fail++; $display("FAIL flush_survivor: got en=%b pc=%h tgt=%h occ=%0d expected en=1 pc=40 tgt=80 occ=1",
                         update_EN, update_pc, update_target, occupancy);
    end
    n_checks++;
    if (drop_count !== 16'd14) begin n_fail++; $display("FAIL flush_drop: got %0d expected 14", drop_count); end
    idle();
    // Flush without a port-0 resolution leaves the FIFO empty.
    dual(XLEN'(32'h600));
    drive_cycle(2'b10, '0, 1'b0, '0, XLEN'(32'h604), 1'b1, XLEN'(32'h700), 1'b1);
    n_checks++;
    if (update_EN !== 1'b0 || occupancy !== 4'd2) begin
      n_fail++; $display("FAIL flush2_cycle: got en=%b occ=%0d expected en=0 occ=2", update_EN, occupancy);
    end
    idle();
    n_checks++;
    if (update_EN !== 1'b0 || occupancy !== 4'd0 || drop_count !== 16'd17) begin
      n_fail++; $display("FAIL flush2_after: got en=%b occ=%0d drop=%0d expected en=0 occ=0 drop=17",
                         update_EN, occupancy, drop_count);
    end
  endtask

  // Steady one-in/one-out traffic through 20 entries, alternating ports, wraps pointers.
  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0)
        drive_cycle(2'b01, XLEN'(32'h1000) + XLEN'(4 * i), 1'b1, XLEN'(32'h3000) + XLEN'(i), '0, 1'b0, '0, 1'b0);
      else
        drive_cycle(2'b10, '0, 1'b0, '0, XLEN'(32'h1000) + XLEN'(4 * i), 1'b0, XLEN'(32'h3000) + XLEN'(i), 1'b0);
      if (i == 10 || i == 19) begin
        n_checks++;
        if (occupancy !== 4'd1 || update_EN !== 1'b1 || update_pc !== XLEN'(32'h1000) + XLEN'(4 * (i - 1))) begin
          n_fail++; $display("FAIL wrap_i%0d: got occ=%0d en=%b pc=%h expected occ=1 en=1 pc=%h",
                             i, occupancy, update_EN, update_pc, XLEN'(32'h1000) + XLEN'(4 * (i - 1)));
        end
      end
    end
    idle();
    idle();
    n_checks++;
    if (occupancy !== 4'd0) begin n_fail++; $display("FAIL wrap_drain: got occ=%0d expected 0", occupancy); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) dual(XLEN'(32'h800) + XLEN'(8 * k));
    @(posedge clock);
    #1;
    resolve_valid = '0;
    flush         = 1'b0;
    n_checks++;
    if (occupancy !== 4'd4) begin n_fail++; $display("FAIL rstmid_pre_occ: got %0d expected 4", occupancy); end
    reset = 1'b0;
    #1;
    n_checks++;
    if (occupancy !== 4'd0 || update_EN !== 1'b0 || resolve_ready !== 1'b1 || drop_count !== 16'd0) begin
      n_fail++; $display("FAIL rstmid_state: got occ=%0d en=%b ready=%b drop=%0d expected occ=0 en=0 ready=1 drop=0",
                         occupancy, update_EN, resolve_ready, drop_count);
    end
    sb.delete();
    m_drop = 0;
    @(negedge clock);
    #2 reset = 1'b1;
    drive_cycle(2'b01, XLEN'(32'h900), 1'b0, XLEN'(32'h940), '0, 1'b0, '0, 1'b0);
    idle();
    n_checks++;
    if (occupancy !== 4'd1 || update_pc !== XLEN'(32'h900)) begin
      n_fail++; $display("FAIL rstmid_recover: got occ=%0d pc=%h expected occ=1 pc=900", occupancy, update_pc);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual_fill();
    test_overflow();
    test_flush();
    test_wrap();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d entries expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
